// File: rtl/clk_div_ctrl_pkg.sv
// Shared types for the clock-divider controller.
//   constants : FSM state encoding for clk_div_ctrl.
//   wires     : config record (half-period minus 1, enable) that bus-side
//               config registers can hold and drive straight onto the cfg port.
package constants;
  typedef enum logic [1:0] {
    STOP = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } clk_div_ctrl_state_t;
endpackage

package wires;
  // Matches the default MAX_DIV of 1024.
  localparam int CFG_HALF_W = 10;

  typedef struct packed {
    logic [CFG_HALF_W-1:0] half;
    logic                  en;
  } clk_div_cfg_t;
endpackage

// File: rtl/clk_div_ctrl_if.sv
// Config handshake for clk_div_ctrl.
//   cfg_valid : request from the bus side
//   cfg_ready : controller can take a config (low while one is pending)
//   cfg_half  : new half-period minus 1
//   cfg_en    : 1 = run with cfg_half, 0 = stop
interface clk_div_ctrl_if #(
  parameter int W = 10
);
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_half;
  logic         cfg_en;

  modport master (output cfg_valid, output cfg_half, output cfg_en, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_half, input cfg_en, output cfg_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Runtime-reconfigurable clock divider. Produces clock_per (idles high) and a
// one-cycle tick on each rising edge of clock_per. New ratios and start/stop
// requests arrive over the cfg handshake and are applied only at the end of a
// low phase, so clock_per never emits a short phase.
//   clock     : system clock
//   reset     : asynchronous, active-low
//   cfg       : config handshake (slave side)
//   clock_per : divided clock
//   tick      : pulse in the first cycle of every high phase
//   running   : 1 in RUN or PEND
//   cur_half  : half-period minus 1 currently in effect
//
// state | meaning
// ------+---------------------------------------------------------------
// STOP  | divider halted, clock_per held high, count held at 0
// RUN   | dividing with half, ready for a new config
// PEND  | dividing with half, a config waits for the next low->high edge
module clk_div_ctrl
  import constants::*;
#(
  parameter int MAX_DIV      = 1024,
  parameter int DEFAULT_HALF = 49,
  localparam int W           = $clog2(MAX_DIV)
) (
  input  logic          clock,
  input  logic          reset,
  clk_div_ctrl_if.slave cfg,
  output logic          clock_per,
  output logic          tick,
  output logic          running,
  output logic [W-1:0]  cur_half
);

  clk_div_ctrl_state_t state, state_n;
  logic [W-1:0] count, count_n;
  logic [W-1:0] half, half_n;
  logic [W-1:0] pend_half, pend_half_n;
  logic         pend_en, pend_en_n;
  logic         clock_per_n;
  logic         tick_n;
  logic         ready;
  logic         accept;
  logic         at_top;
  logic         boundary;

  assign ready         = (state != PEND);
  assign cfg.cfg_ready = ready;
  assign accept        = cfg.cfg_valid & ready;
  assign running       = (state != STOP);
  assign cur_half      = half;
  assign at_top        = (count == half);
  // End of the low phase: the output is about to rise.
  assign boundary      = at_top & ~clock_per;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      count     <= '0;
      half      <= W'(DEFAULT_HALF);
      pend_half <= '0;
      pend_en   <= 1'b0;
      clock_per <= 1'b1;
      tick      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      half      <= half_n;
      pend_half <= pend_half_n;
      pend_en   <= pend_en_n;
      clock_per <= clock_per_n;
      tick      <= tick_n;
    end
  end

  always_comb begin
    state_n     = state;
    count_n     = count;
    half_n      = half;
    pend_half_n = pend_half;
    pend_en_n   = pend_en;
    clock_per_n = clock_per;
    tick_n      = 1'b0;

    case (state)
      STOP: begin
        count_n     = '0;
        clock_per_n = 1'b1;
        if (accept) begin
          half_n = cfg.cfg_half;
          if (cfg.cfg_en) state_n = RUN;
        end
      end
      RUN, PEND: begin
        if (at_top) begin
          count_n     = '0;
          clock_per_n = ~clock_per;
          tick_n      = ~clock_per;
        end else begin
          count_n = count + W'(1);
        end
        // A config accepted on a boundary cycle lands in PEND after that
        // boundary has already been taken, so it waits a full period.
        if (state == RUN && accept) begin
          pend_half_n = cfg.cfg_half;
          pend_en_n   = cfg.cfg_en;
          state_n     = PEND;
        end
        if (state == PEND && boundary) begin
          half_n  = pend_half;
          state_n = pend_en ? RUN : STOP;
        end
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
module tb_clk_div_ctrl;
  import wires::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       clock_per;
  logic       tick;
  logic       running;
  logic [9:0] cur_half;
  int         n_checks = 0;
  int         n_fail   = 0;

  clk_div_ctrl_if #(.W(10)) cfg_if ();

  clk_div_ctrl #(.MAX_DIV(1024), .DEFAULT_HALF(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .cfg       (cfg_if.slave),
    .clock_per (clock_per),
    .tick      (tick),
    .running   (running),
    .cur_half  (cur_half)
  );

  always #5 clock = ~clock;

  task automatic drive_cfg(input logic v, input logic [9:0] h, input logic e);
    clk_div_cfg_t c;
    c.half = h;
    c.en   = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_half  = c.half;
    cfg_if.cfg_en    = c.en;
  endtask

  task automatic step();
    @(negedge clock);
  endtask

  // Default divider after reset: H=4, 10-cycle period, c counts clock edges since release.
  task automatic check_default_run(input string tag);
    logic ec, et;
    for (int c = 1; c <= 20; c++) begin
      step();
      ec = ((c % 10) < 5);
      et = ((c % 10) == 0);
      n_checks++; if (clock_per !== ec) begin n_fail++; $display("FAIL %s_clock_per c=%0d got=%0b exp=%0b", tag, c, clock_per, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL %s_tick c=%0d got=%0b exp=%0b", tag, c, tick, et); end
      n_checks++; if (cur_half !== 10'd4) begin n_fail++; $display("FAIL %s_cur_half c=%0d got=%0d exp=4", tag, c, cur_half); end
      n_checks++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL %s_ready c=%0d got=%0b exp=1", tag, c, cfg_if.cfg_ready); end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_cfg(1'b0, 10'd0, 1'b0);
    #12;
    n_checks++; if (clock_per !== 1'b1) begin n_fail++; $display("FAIL rst_clock_per got=%0b exp=1", clock_per); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rst_tick got=%0b exp=0", tick); end
    n_checks++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready got=%0b exp=1", cfg_if.cfg_ready); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL rst_running got=%0b exp=1", running); end
    n_checks++; if (cur_half !== 10'd4) begin n_fail++; $display("FAIL rst_cur_half got=%0d exp=4", cur_half); end
    step();
    reset = 1'b1;
    check_default_run("reset_run");
  endtask

  // Enters at the first cycle of a high phase with H=4.
  task automatic test_reconfig();
    logic ec, et;
    step();
    drive_cfg(1'b1, 10'd1, 1'b1);
    step();
    drive_cfg(1'b0, 10'd0, 1'b0);
    for (int c = 22; c <= 29; c++) begin
      if (c > 22) step();
      ec = ((c % 10) < 5);
      n_checks++; if (clock_per !== ec) begin n_fail++; $display("FAIL reconf_old_clock_per c=%0d got=%0b exp=%0b", c, clock_per, ec); end
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL reconf_old_tick c=%0d got=%0b exp=0", c, tick); end
      n_checks++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL reconf_ready c=%0d got=%0b exp=0", c, cfg_if.cfg_ready); end
      n_checks++; if (cur_half !== 10'd4) begin n_fail++; $display("FAIL reconf_old_half c=%0d got=%0d exp=4", c, cur_half); end
    end
    for (int d = 0; d <= 11; d++) begin
      step();
      ec = ((d % 4) < 2);
      et = ((d % 4) == 0);
      n_checks++; if (clock_per !== ec) begin n_fail++; $display("FAIL reconf_new_clock_per d=%0d got=%0b exp=%0b", d, clock_per, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL reconf_new_tick d=%0d got=%0b exp=%0b", d, tick, et); end
      n_checks++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reconf_new_ready d=%0d got=%0b exp=1", d, cfg_if.cfg_ready); end
      n_checks++; if (cur_half !== 10'd1) begin n_fail++; $display("FAIL reconf_new_half d=%0d got=%0d exp=1", d, cur_half); end
    end
  endtask

  // Enters at the last low cycle with H=1; stop request accepted mid low phase.
  task automatic test_stop();
    step();
    step();
    step();
    drive_cfg(1'b1, 10'd2, 1'b0);
    step();
    drive_cfg(1'b0, 10'd0, 1'b0);
    n_checks++; if (clock_per !== 1'b0) begin n_fail++; $display("FAIL stop_pend_clock_per got=%0b exp=0", clock_per); end
    n_checks++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL stop_pend_ready got=%0b exp=0", cfg_if.cfg_ready); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL stop_pend_running got=%0b exp=1", running); end
    step();
    n_checks++; if (clock_per !== 1'b1) begin n_fail++; $display("FAIL stop_rise_clock_per got=%0b exp=1", clock_per); end
    n_checks++; if (tick !== 1'b1) begin n_fail++; $display("FAIL stop_rise_tick got=%0b exp=1", tick); end
    n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_running got=%0b exp=0", running); end
    n_checks++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL stop_ready got=%0b exp=1", cfg_if.cfg_ready); end
    n_checks++; if (cur_half !== 10'd2) begin n_fail++; $display("FAIL stop_cur_half got=%0d exp=2", cur_half); end
    for (int k = 0; k < 10; k++) begin
      step();
      n_checks++; if (clock_per !== 1'b1) begin n_fail++; $display("FAIL stop_hold_clock_per k=%0d got=%0b exp=1", k, clock_per); end
      n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL stop_hold_tick k=%0d got=%0b exp=0", k, tick); end
      n_checks++; if (running !== 1'b0) begin n_fail++; $display("FAIL stop_hold_running k=%0d got=%0b exp=0", k, running); end
    end
  endtask

  // From STOP, start with H=0 (divide by 2).
  task automatic test_start_div2();
    logic ec, et;
    drive_cfg(1'b1, 10'd0, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 1) drive_cfg(1'b0, 10'd0, 1'b0);
      ec = (((e - 1) % 2) == 0);
      et = (e > 1) && ec;
      n_checks++; if (clock_per !== ec) begin n_fail++; $display("FAIL start_clock_per e=%0d got=%0b exp=%0b", e, clock_per, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL start_tick e=%0d got=%0b exp=%0b", e, tick, et); end
      n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL start_running e=%0d got=%0b exp=1", e, running); end
      n_checks++; if (cur_half !== 10'd0) begin n_fail++; $display("FAIL start_cur_half e=%0d got=%0d exp=0", e, cur_half); end
    end
  endtask

  // Configs accepted exactly on boundary cycles: first with H=0, then with H=3.
  task automatic test_back_to_back();
    logic ec, et, er;
    logic [9:0] eh;
    drive_cfg(1'b1, 10'd3, 1'b1);
    step();
    drive_cfg(1'b0, 10'd0, 1'b0);
    n_checks++; if (clock_per !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL b2b_h0_rise got=%0b/%0b exp=1/1", clock_per, tick); end
    n_checks++; if (cur_half !== 10'd0) begin n_fail++; $display("FAIL b2b_h0_half_kept got=%0d exp=0", cur_half); end
    n_checks++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_h0_ready got=%0b exp=0", cfg_if.cfg_ready); end
    step();
    n_checks++; if (clock_per !== 1'b0 || cur_half !== 10'd0) begin n_fail++; $display("FAIL b2b_h0_low got=%0b/%0d exp=0/0", clock_per, cur_half); end
    step();
    n_checks++; if (clock_per !== 1'b1 || tick !== 1'b1) begin n_fail++; $display("FAIL b2b_h3_rise got=%0b/%0b exp=1/1", clock_per, tick); end
    n_checks++; if (cur_half !== 10'd3) begin n_fail++; $display("FAIL b2b_h3_half got=%0d exp=3", cur_half); end
    n_checks++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_h3_ready got=%0b exp=1", cfg_if.cfg_ready); end
    for (int f = 1; f <= 16; f++) begin
      step();
      if (f == 8) drive_cfg(1'b0, 10'd0, 1'b0);
      ec = ((f % 8) < 4);
      et = ((f % 8) == 0);
      er = (f < 8) || (f >= 16);
      eh = (f < 16) ? 10'd3 : 10'd5;
      n_checks++; if (clock_per !== ec) begin n_fail++; $display("FAIL b2b_clock_per f=%0d got=%0b exp=%0b", f, clock_per, ec); end
      n_checks++; if (tick !== et) begin n_fail++; $display("FAIL b2b_tick f=%0d got=%0b exp=%0b", f, tick, et); end
      n_checks++; if (cfg_if.cfg_ready !== er) begin n_fail++; $display("FAIL b2b_ready f=%0d got=%0b exp=%0b", f, cfg_if.cfg_ready, er); end
      n_checks++; if (cur_half !== eh) begin n_fail++; $display("FAIL b2b_cur_half f=%0d got=%0d exp=%0d", f, cur_half, eh); end
      if (f == 7) drive_cfg(1'b1, 10'd5, 1'b1);
    end
  endtask

  // Enters at the first high cycle with H=5; reset hits while a config is pending.
  task automatic test_reset_mid_pend();
    logic ec;
    drive_cfg(1'b1, 10'd2, 1'b1);
    for (int g = 1; g <= 7; g++) begin
      step();
      if (g == 1) drive_cfg(1'b0, 10'd0, 1'b0);
      ec = (g < 6);
      n_checks++; if (clock_per !== ec) begin n_fail++; $display("FAIL rpend_clock_per g=%0d got=%0b exp=%0b", g, clock_per, ec); end
      n_checks++; if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rpend_ready g=%0d got=%0b exp=0", g, cfg_if.cfg_ready); end
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++; if (clock_per !== 1'b1) begin n_fail++; $display("FAIL rpend_async_clock_per got=%0b exp=1", clock_per); end
    n_checks++; if (tick !== 1'b0) begin n_fail++; $display("FAIL rpend_async_tick got=%0b exp=0", tick); end
    n_checks++; if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL rpend_async_ready got=%0b exp=1", cfg_if.cfg_ready); end
    n_checks++; if (running !== 1'b1) begin n_fail++; $display("FAIL rpend_async_running got=%0b exp=1", running); end
    n_checks++; if (cur_half !== 10'd4) begin n_fail++; $display("FAIL rpend_async_cur_half got=%0d exp=4", cur_half); end
    step();
    step();
    n_checks++; if (clock_per !== 1'b1 || cur_half !== 10'd4) begin n_fail++; $display("FAIL rpend_hold got=%0b/%0d exp=1/4", clock_per, cur_half); end
    reset = 1'b1;
    check_default_run("rpend_after");
  endtask

  initial begin
    test_reset();
    test_reconfig();
    test_stop();
    test_start_div2();
    test_back_to_back();
    test_reset_mid_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
